// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package ifu_pkg;

  localparam int IFU_INST_BYTES = 4;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_inst_fifo.sv
// Synchronous instruction buffer; flush resets both pointers and wins over push/pop.
module ifu_inst_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  ifu_entry_t             push_data,
  input  logic                   pop,
  output ifu_entry_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  ifu_entry_t  mem_q [DEPTH];
  ifu_entry_t  mem_d [DEPTH];
  logic        full;

  // The extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push && !full) begin
        mem_d[wr_ptr_q[AW-1:0]] = push_data;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: sequential PC generation, in-order memory requests,
// buffered delivery to decode, redirect flush. Optional IFU_PERF_CNT_EN adds perf counters.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h8000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTST  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifetch_taken,
  input  logic [63:0] ifetch_taken_pc,
  output logic        imem_req_vld,
  input  logic        imem_req_rdy,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_vld,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_inst_vld,
  input  logic        dec_inst_rdy,
  output logic [31:0] dec_inst,
  output logic [63:0] dec_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [63:0] perf_fetched,
  output logic [63:0] perf_dropped,
  output logic [63:0] perf_redirects
`endif
);

  localparam int CW = $clog2(MAX_OUTST + 1);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;

  logic [63:0]   pc_q, pc_d;
  logic [63:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outst_cnt_q, outst_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          run_q, run_d;

  logic [FW-1:0] fifo_cnt;
  logic          fifo_empty;
  ifu_entry_t    fifo_head;
  ifu_entry_t    push_entry;
  logic [63:0]   target_pc;
  logic          issue, rsp_drop, push, pop;

  assign target_pc = ifetch_taken_pc & ~64'h3;

  // run_q holds requests off until the first clock after reset release.
  assign imem_req_vld = run_q && !ifetch_taken
                        && (int'(outst_cnt_q) < MAX_OUTST)
                        && (int'(outst_cnt_q) + int'(fifo_cnt) < FIFO_DEPTH);
  assign imem_req_addr = pc_q;
  assign issue         = imem_req_vld && imem_req_rdy;

  assign rsp_drop = imem_rsp_vld && (drop_cnt_q != '0);
  assign push     = imem_rsp_vld && !rsp_drop && !ifetch_taken;
  assign pop      = dec_inst_vld && dec_inst_rdy;

  assign push_entry.inst = imem_rsp_data;
  assign push_entry.pc   = rsp_pc_q;

  assign dec_inst_vld = !fifo_empty && !ifetch_taken;
  assign dec_inst     = fifo_empty ? 32'd0 : fifo_head.inst;
  assign dec_pc       = fifo_empty ? 64'd0 : fifo_head.pc;

  ifu_inst_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (ifetch_taken),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_cnt),
    .empty     (fifo_empty)
  );

  always_comb begin
    run_d       = 1'b1;
    pc_d        = pc_q;
    rsp_pc_d    = rsp_pc_q;
    outst_cnt_d = outst_cnt_q + CW'(issue) - CW'(imem_rsp_vld);
    drop_cnt_d  = drop_cnt_q;
    if (issue) pc_d = pc_q + 64'(IFU_INST_BYTES);
    if (push) rsp_pc_d = rsp_pc_q + 64'(IFU_INST_BYTES);
    if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    // Every request still outstanding after this cycle belongs to the old stream;
    // drop_cnt never exceeds outst_cnt, so this also absorbs an earlier redirect.
    if (ifetch_taken) begin
      pc_d       = target_pc;
      rsp_pc_d   = target_pc;
      drop_cnt_d = outst_cnt_q - CW'(imem_rsp_vld);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      pc_q        <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      outst_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      run_q       <= run_d;
      pc_q        <= pc_d;
      rsp_pc_q    <= rsp_pc_d;
      outst_cnt_q <= outst_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic en);
    return (en && (v != '1)) ? v + 64'd1 : v;
  endfunction

  logic [63:0] perf_fetched_q, perf_fetched_d;
  logic [63:0] perf_dropped_q, perf_dropped_d;
  logic [63:0] perf_redirects_q, perf_redirects_d;

  always_comb begin
    perf_fetched_d   = sat_inc(perf_fetched_q, push);
    perf_dropped_d   = sat_inc(perf_dropped_q, imem_rsp_vld && !push);
    perf_redirects_d = sat_inc(perf_redirects_q, ifetch_taken);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q   <= '0;
      perf_dropped_q   <= '0;
      perf_redirects_q <= '0;
    end else begin
      perf_fetched_q   <= perf_fetched_d;
      perf_dropped_q   <= perf_dropped_d;
      perf_redirects_q <= perf_redirects_d;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_dropped   = perf_dropped_q;
  assign perf_redirects = perf_redirects_q;
`endif

endmodule
